// File: rtl/aux_crossbar.sv
// aux_crossbar: round-robin arbitration of aux masters onto address-decoded
// peripheral ports, with per-slave read-response FIFOs, credit counters and
// a single error slot that answers reads to unmapped addresses.
module aux_crossbar #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES = 2,
  parameter int TAG_W = 9,
  parameter logic [16*NUM_SLAVES-1:0] SLAVE_BASE = {16'hFFFF, 16'hE000},
  parameter logic [16*NUM_SLAVES-1:0] SLAVE_MASK = {16'hFFFF, 16'hFFFF},
  parameter int RESP_DEPTH = 4,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
  localparam int SRC_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_MASTERS-1:0]       m_request,
  output logic [NUM_MASTERS-1:0]       m_ack,
  input  logic [NUM_MASTERS-1:0]       m_write,
  input  logic [32*NUM_MASTERS-1:0]    m_addr,
  input  logic [4*NUM_MASTERS-1:0]     m_wstrb,
  input  logic [32*NUM_MASTERS-1:0]    m_wdata,
  input  logic [TAG_W*NUM_MASTERS-1:0] m_tag,
  input  logic [NUM_MASTERS-1:0]       m_abort,
  output logic [NUM_SLAVES-1:0]        s_request,
  output logic                         s_write,
  output logic [15:0]                  s_addr,
  output logic [3:0]                   s_wmask,
  output logic [31:0]                  s_wdata,
  output logic [TAG_W-1:0]             s_tag,
  input  logic [NUM_SLAVES-1:0]        s_rvalid,
  input  logic [TAG_W*NUM_SLAVES-1:0]  s_rtag,
  input  logic [32*NUM_SLAVES-1:0]     s_rdata,
  output logic                         r_valid,
  output logic [31:0]                  r_data,
  output logic [TAG_W-1:0]             r_tag,
  output logic [SRC_W-1:0]             r_src
);

  localparam int AW = $clog2(RESP_DEPTH);
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int NSRC = NUM_SLAVES + 1;
  localparam int DW = $clog2(NSRC);

  logic [NUM_SLAVES-1:0]  m_hit [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] m_mapped, eligible;
  logic [SRC_W-1:0]       rr_ptr, grant_idx, cand_m;
  logic                   grant_any;

  logic                   issue_valid, issue_unmapped, issue_live;
  logic [SRC_W-1:0]       issue_src;
  logic [NUM_SLAVES-1:0]  issue_hit, issue_rd, rd_ok;

  logic                   err_ok, err_valid, err_load, err_pop;
  logic [TAG_W-1:0]       err_tag;
  logic [SRC_W-1:0]       err_src;

  logic [CW-1:0]          credits [NUM_SLAVES];
  logic [SRC_W-1:0]       srcq    [NUM_SLAVES][RESP_DEPTH];
  logic [AW-1:0]          sq_wr   [NUM_SLAVES];
  logic [AW-1:0]          sq_rd   [NUM_SLAVES];
  logic [TAG_W-1:0]       f_tag   [NUM_SLAVES][RESP_DEPTH];
  logic [31:0]            f_data  [NUM_SLAVES][RESP_DEPTH];
  logic [SRC_W-1:0]       f_src   [NUM_SLAVES][RESP_DEPTH];
  logic [AW:0]            f_wr    [NUM_SLAVES];
  logic [AW:0]            f_rd    [NUM_SLAVES];
  logic [NUM_SLAVES-1:0]  fifo_empty, slv_pop;

  logic [NSRC-1:0]        src_rdy;
  logic [DW-1:0]          drain_ptr, drain_sel, cand_d;
  logic                   drain_any;
  logic [31:0]            hd_data;
  logic [TAG_W-1:0]       hd_tag;
  logic [SRC_W-1:0]       hd_src;

  // Address decode per master; lowest matching slave wins.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      m_hit[i] = '0;
      m_mapped[i] = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (!m_mapped[i] &&
            ((m_addr[32*i+16 +: 16] & SLAVE_MASK[16*k +: 16]) ==
             (SLAVE_BASE[16*k +: 16] & SLAVE_MASK[16*k +: 16]))) begin
          m_hit[i][k] = 1'b1;
          m_mapped[i] = 1'b1;
        end
      end
    end
  end

  // Acceptability: the read sitting in the issue stage is counted against
  // the credits so back-to-back reads can never oversubscribe a FIFO.
  always_comb begin
    issue_live = issue_valid && !m_abort[issue_src];
    for (int k = 0; k < NUM_SLAVES; k++) begin
      issue_rd[k] = issue_live && !s_write && issue_hit[k];
      rd_ok[k] = (int'(credits[k]) + int'(issue_rd[k])) < RESP_DEPTH;
    end
    err_ok = !err_valid && !(issue_valid && !s_write && issue_unmapped);
    err_load = issue_live && !s_write && issue_unmapped;
    for (int i = 0; i < NUM_MASTERS; i++)
      eligible[i] = m_request[i] &&
                    (m_write[i] || (m_mapped[i] ? |(m_hit[i] & rd_ok) : err_ok));
  end

  // Round-robin grant starting at the pointer.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_m = '0;
    m_ack = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      cand_m = SRC_W'((int'(rr_ptr) + j) % NUM_MASTERS);
      if (!grant_any && eligible[cand_m]) begin
        grant_any = 1'b1;
        grant_idx = cand_m;
      end
    end
    if (grant_any) m_ack[grant_idx] = 1'b1;
  end

  assign s_request = issue_live ? issue_hit : '0;

  // Issue stage register and round-robin pointer update.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      issue_valid <= 1'b0;
      issue_src <= '0;
      issue_hit <= '0;
      issue_unmapped <= 1'b0;
      s_write <= 1'b0;
      s_addr <= '0;
      s_wmask <= '0;
      s_wdata <= '0;
      s_tag <= '0;
    end else begin
      issue_valid <= grant_any;
      issue_src <= grant_idx;
      issue_hit <= m_hit[grant_idx];
      issue_unmapped <= !m_mapped[grant_idx];
      s_write <= m_write[grant_idx];
      s_addr <= m_addr[32*grant_idx +: 16];
      s_wmask <= m_wstrb[4*grant_idx +: 4];
      s_wdata <= m_wdata[32*grant_idx +: 32];
      s_tag <= m_tag[TAG_W*grant_idx +: TAG_W];
      if (grant_any) rr_ptr <= SRC_W'((int'(grant_idx) + 1) % NUM_MASTERS);
    end
  end

  // Drain source selection: round-robin over non-empty FIFOs and the error slot.
  always_comb begin
    for (int k = 0; k < NUM_SLAVES; k++) fifo_empty[k] = (f_wr[k] == f_rd[k]);
    src_rdy = {err_valid, ~fifo_empty};
    drain_any = 1'b0;
    drain_sel = '0;
    cand_d = '0;
    for (int j = 0; j < NSRC; j++) begin
      cand_d = DW'((int'(drain_ptr) + j) % NSRC);
      if (!drain_any && src_rdy[cand_d]) begin
        drain_any = 1'b1;
        drain_sel = cand_d;
      end
    end
    err_pop = drain_any && (drain_sel == DW'(NUM_SLAVES));
    hd_data = '0;
    hd_tag = '0;
    hd_src = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      slv_pop[k] = drain_any && (drain_sel == DW'(k));
      if (slv_pop[k]) begin
        hd_data = f_data[k][f_rd[k][AW-1:0]];
        hd_tag = f_tag[k][f_rd[k][AW-1:0]];
        hd_src = f_src[k][f_rd[k][AW-1:0]];
      end
    end
  end

  // Queue storage: issuing-master record at issue, slave response on rvalid.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (issue_rd[k]) srcq[k][sq_wr[k]] <= issue_src;
      if (s_rvalid[k]) begin
        f_tag[k][f_wr[k][AW-1:0]] <= s_rtag[TAG_W*k +: TAG_W];
        f_data[k][f_wr[k][AW-1:0]] <= s_rdata[32*k +: 32];
        f_src[k][f_wr[k][AW-1:0]] <= srcq[k][sq_rd[k]];
      end
    end
  end

  // Pointers, credits, error slot and the registered response port.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        sq_wr[k] <= '0;
        sq_rd[k] <= '0;
        f_wr[k] <= '0;
        f_rd[k] <= '0;
        credits[k] <= '0;
      end
      err_valid <= 1'b0;
      err_tag <= '0;
      err_src <= '0;
      drain_ptr <= '0;
      r_valid <= 1'b0;
      r_data <= '0;
      r_tag <= '0;
      r_src <= '0;
    end else begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (issue_rd[k]) sq_wr[k] <= sq_wr[k] + AW'(1);
        if (s_rvalid[k]) begin
          sq_rd[k] <= sq_rd[k] + AW'(1);
          f_wr[k] <= f_wr[k] + (AW+1)'(1);
        end
        if (slv_pop[k]) f_rd[k] <= f_rd[k] + (AW+1)'(1);
        if (issue_rd[k] && !slv_pop[k]) credits[k] <= credits[k] + CW'(1);
        else if (!issue_rd[k] && slv_pop[k]) credits[k] <= credits[k] - CW'(1);
      end
      if (err_load) begin
        err_valid <= 1'b1;
        err_tag <= s_tag;
        err_src <= issue_src;
      end else if (err_pop) begin
        err_valid <= 1'b0;
      end
      r_valid <= drain_any;
      if (drain_any) begin
        drain_ptr <= DW'((int'(drain_sel) + 1) % NSRC);
        if (err_pop) begin
          r_data <= ERR_DATA;
          r_tag <= err_tag;
          r_src <= err_src;
        end else begin
          r_data <= hd_data;
          r_tag <= hd_tag;
          r_src <= hd_src;
        end
      end
    end
  end

endmodule

// File: tb/tb_aux_crossbar.sv
// tb_aux_crossbar: directed scenario tests for aux_crossbar (default parameters).
module tb_aux_crossbar;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [1:0]  m_request, m_ack, m_write, m_abort;
  logic [63:0] m_addr, m_wdata;
  logic [7:0]  m_wstrb;
  logic [17:0] m_tag;
  logic [1:0]  s_request;
  logic        s_write;
  logic [15:0] s_addr;
  logic [3:0]  s_wmask;
  logic [31:0] s_wdata;
  logic [8:0]  s_tag;
  logic [1:0]  s_rvalid;
  logic [17:0] s_rtag;
  logic [63:0] s_rdata;
  logic        r_valid;
  logic [31:0] r_data;
  logic [8:0]  r_tag;
  logic [0:0]  r_src;

  int total = 0;
  int bad = 0;
  int ovf_cnt = 0;

  aux_crossbar dut (
    .clock(clock), .reset_n(reset_n),
    .m_request(m_request), .m_ack(m_ack), .m_write(m_write), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata), .m_tag(m_tag), .m_abort(m_abort),
    .s_request(s_request), .s_write(s_write), .s_addr(s_addr), .s_wmask(s_wmask),
    .s_wdata(s_wdata), .s_tag(s_tag), .s_rvalid(s_rvalid), .s_rtag(s_rtag),
    .s_rdata(s_rdata), .r_valid(r_valid), .r_data(r_data), .r_tag(r_tag),
    .r_src(r_src)
  );

  always #5 clock = ~clock;

  // A response pushed into a full FIFO must never occur.
  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      for (int k = 0; k < 2; k++) begin
        if (s_rvalid[k] && ((dut.f_wr[k] - dut.f_rd[k]) == 3'd4)) ovf_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    m_request = '0; m_write = '0; m_abort = '0;
    m_addr = '0; m_wdata = '0; m_wstrb = '0; m_tag = '0;
    s_rvalid = '0; s_rtag = '0; s_rdata = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
  endtask

  task automatic set_m(input int i, input logic wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [8:0] tag);
    m_request[i] = 1'b1;
    m_write[i] = wr;
    m_addr[32*i +: 32] = addr;
    m_wdata[32*i +: 32] = data;
    m_wstrb[4*i +: 4] = 4'hF;
    m_tag[9*i +: 9] = tag;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) tick();
    #4;
    total++; if (s_request !== 2'b00) begin bad++; $display("FAIL rst_sreq: got %b want 00", s_request); end
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", r_valid); end
    total++; if (r_data !== 32'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", r_data); end
    total++; if (r_tag !== 9'h0) begin bad++; $display("FAIL rst_rtag: got %h want 0", r_tag); end
    total++; if (r_src !== 1'b0) begin bad++; $display("FAIL rst_rsrc: got %b want 0", r_src); end
    total++; if (m_ack !== 2'b00) begin bad++; $display("FAIL rst_ack: got %b want 00", m_ack); end
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_single_write();
    do_reset();
    set_m(0, 1'b1, 32'hE0000010, 32'h12345678, 9'h0);
    #4;
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL wr_ack: got %b want 01", m_ack); end
    tick();
    m_request = '0;
    #4;
    total++; if (s_request !== 2'b01) begin bad++; $display("FAIL wr_sreq: got %b want 01", s_request); end
    total++; if (s_addr !== 16'h0010) begin bad++; $display("FAIL wr_saddr: got %h want 0010", s_addr); end
    total++; if (s_wdata !== 32'h12345678) begin bad++; $display("FAIL wr_swdata: got %h want 12345678", s_wdata); end
    total++; if (s_write !== 1'b1 || s_wmask !== 4'hF) begin bad++; $display("FAIL wr_ctl: got w=%b m=%h want w=1 m=F", s_write, s_wmask); end
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL wr_rvalid: got %b want 0", r_valid); end
    tick();
    #4;
    total++; if (s_request !== 2'b00 || r_valid !== 1'b0) begin bad++; $display("FAIL wr_after: got sreq=%b rv=%b want 00/0", s_request, r_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_m(0, 1'b1, 32'hE0000100, 32'h00000100, 9'h0);
    set_m(1, 1'b1, 32'hE0000200, 32'h00000200, 9'h0);
    for (int c = 0; c < 4; c++) begin
      #4;
      total++;
      if (m_ack !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_ack[%0d]: got %b want %b", c, m_ack, (c % 2 == 0) ? 2'b01 : 2'b10); end
      if (c > 0) begin
        total++;
        if (s_request !== 2'b01 || s_addr !== ((c % 2 == 1) ? 16'h0100 : 16'h0200)) begin
          bad++; $display("FAIL rr_issue[%0d]: got sreq=%b addr=%h want 01/%h", c, s_request, s_addr, (c % 2 == 1) ? 16'h0100 : 16'h0200);
        end
      end
      tick();
    end
    m_request = '0;
    #4;
    total++; if (s_request !== 2'b01 || s_addr !== 16'h0200) begin bad++; $display("FAIL rr_last: got sreq=%b addr=%h want 01/0200", s_request, s_addr); end
    tick();
  endtask

  task automatic test_abort();
    int seen;
    do_reset();
    set_m(0, 1'b0, 32'hFFFF0004, 32'h0, 9'h005);
    #4;
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL ab_ack: got %b want 01", m_ack); end
    tick();
    m_request = '0;
    m_abort = 2'b01;
    #4;
    total++; if (s_request !== 2'b00) begin bad++; $display("FAIL ab_sreq: got %b want 00", s_request); end
    tick();
    m_abort = '0;
    #4;
    total++; if (dut.credits[1] !== 3'd0) begin bad++; $display("FAIL ab_credit: got %0d want 0", dut.credits[1]); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (r_valid !== 1'b0 || s_request !== 2'b00) seen++;
      tick();
      #4;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL ab_quiet: got %0d active cycles want 0", seen); end
  endtask

  task automatic test_simul_resp();
    do_reset();
    set_m(0, 1'b0, 32'hE0000000, 32'h0, 9'h011);
    #4;
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL sr_ack0: got %b want 01", m_ack); end
    tick();
    m_request = '0;
    set_m(1, 1'b0, 32'hFFFF0000, 32'h0, 9'h022);
    #4;
    total++; if (m_ack !== 2'b10) begin bad++; $display("FAIL sr_ack1: got %b want 10", m_ack); end
    total++; if (s_request !== 2'b01 || s_tag !== 9'h011) begin bad++; $display("FAIL sr_iss0: got %b/%h want 01/011", s_request, s_tag); end
    tick();
    m_request = '0;
    #4;
    total++; if (s_request !== 2'b10 || s_tag !== 9'h022) begin bad++; $display("FAIL sr_iss1: got %b/%h want 10/022", s_request, s_tag); end
    tick();
    s_rvalid = 2'b11;
    s_rtag = {9'h022, 9'h011};
    s_rdata = {32'hBBBB1111, 32'hAAAA0000};
    #4;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL sr_push_rv: got %b want 0", r_valid); end
    tick();
    s_rvalid = '0;
    #4;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL sr_lat_rv: got %b want 0", r_valid); end
    tick();
    #4;
    total++; if (r_valid !== 1'b1 || r_tag !== 9'h011 || r_src !== 1'b0 || r_data !== 32'hAAAA0000) begin
      bad++; $display("FAIL sr_first: got v=%b t=%h s=%b d=%h want 1/011/0/AAAA0000", r_valid, r_tag, r_src, r_data); end
    tick();
    #4;
    total++; if (r_valid !== 1'b1 || r_tag !== 9'h022 || r_src !== 1'b1 || r_data !== 32'hBBBB1111) begin
      bad++; $display("FAIL sr_second: got v=%b t=%h s=%b d=%h want 1/022/1/BBBB1111", r_valid, r_tag, r_src, r_data); end
    tick();
    #4;
    total++; if (r_valid !== 1'b0 || r_data !== 32'hBBBB1111 || r_tag !== 9'h022) begin
      bad++; $display("FAIL sr_hold: got v=%b t=%h d=%h want 0/022/BBBB1111", r_valid, r_tag, r_data); end
  endtask

  task automatic test_credit_stall();
    do_reset();
    for (int n = 0; n < 4; n++) begin
      set_m(0, 1'b0, 32'hE0000000, 32'h0, 9'(n + 1));
      #4;
      total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL cs_ack[%0d]: got %b want 01", n, m_ack); end
      tick();
      m_request = '0;
      tick();
    end
    set_m(0, 1'b0, 32'hE0000000, 32'h0, 9'h005);
    #4;
    total++; if (m_ack !== 2'b00) begin bad++; $display("FAIL cs_stall0: got %b want 00", m_ack); end
    tick();
    #4;
    total++; if (m_ack !== 2'b00) begin bad++; $display("FAIL cs_stall1: got %b want 00", m_ack); end
    tick();
    s_rvalid = 2'b01;
    s_rtag = {9'h0, 9'h001};
    s_rdata = {32'h0, 32'h00000001};
    #4;
    total++; if (m_ack !== 2'b00) begin bad++; $display("FAIL cs_stall2: got %b want 00", m_ack); end
    tick();
    s_rvalid = '0;
    #4;
    total++; if (m_ack !== 2'b00 || r_valid !== 1'b0) begin bad++; $display("FAIL cs_drain: got ack=%b rv=%b want 00/0", m_ack, r_valid); end
    tick();
    #4;
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL cs_resume: got %b want 01", m_ack); end
    total++; if (r_valid !== 1'b1 || r_tag !== 9'h001 || r_src !== 1'b0) begin bad++; $display("FAIL cs_resp: got v=%b t=%h s=%b want 1/001/0", r_valid, r_tag, r_src); end
    tick();
    m_request = '0;
    #4;
    total++; if (s_request !== 2'b01 || s_tag !== 9'h005) begin bad++; $display("FAIL cs_issue5: got %b/%h want 01/005", s_request, s_tag); end
    tick();
  endtask

  task automatic test_unmapped();
    int seen;
    do_reset();
    set_m(1, 1'b0, 32'h12340000, 32'h0, 9'h1FF);
    #4;
    total++; if (m_ack !== 2'b10) begin bad++; $display("FAIL um_ack: got %b want 10", m_ack); end
    tick();
    m_request = '0;
    set_m(0, 1'b0, 32'h12340000, 32'h0, 9'h0AB);
    #4;
    total++; if (m_ack !== 2'b00 || s_request !== 2'b00) begin bad++; $display("FAIL um_t1: got ack=%b sreq=%b want 00/00", m_ack, s_request); end
    tick();
    #4;
    total++; if (m_ack !== 2'b00 || r_valid !== 1'b0) begin bad++; $display("FAIL um_t2: got ack=%b rv=%b want 00/0", m_ack, r_valid); end
    tick();
    #4;
    total++; if (r_valid !== 1'b1 || r_data !== 32'hDEADBEEF || r_tag !== 9'h1FF || r_src !== 1'b1) begin
      bad++; $display("FAIL um_resp: got v=%b d=%h t=%h s=%b want 1/DEADBEEF/1FF/1", r_valid, r_data, r_tag, r_src); end
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL um_ack2: got %b want 01", m_ack); end
    tick();
    m_request = '0;
    #4;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL um_t4: got %b want 0", r_valid); end
    tick();
    #4;
    total++; if (r_valid !== 1'b0) begin bad++; $display("FAIL um_t5: got %b want 0", r_valid); end
    tick();
    #4;
    total++; if (r_valid !== 1'b1 || r_tag !== 9'h0AB || r_src !== 1'b0 || r_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL um_resp2: got v=%b t=%h s=%b d=%h want 1/0AB/0/DEADBEEF", r_valid, r_tag, r_src, r_data); end
    tick();
    set_m(0, 1'b1, 32'h12340000, 32'h00000055, 9'h0);
    #4;
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL umw_ack: got %b want 01", m_ack); end
    tick();
    m_request = '0;
    #4;
    total++; if (s_request !== 2'b00) begin bad++; $display("FAIL umw_sreq: got %b want 00", s_request); end
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (r_valid !== 1'b0) seen++;
      tick();
      #4;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL umw_noresp: got %0d responses want 0", seen); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_m(0, 1'b0, 32'hE0000000, 32'h0, 9'h033);
    #4;
    total++; if (m_ack !== 2'b01) begin bad++; $display("FAIL mr_ack: got %b want 01", m_ack); end
    tick();
    m_request = '0;
    reset_n = 1'b0;
    #4;
    total++; if (s_request !== 2'b01) begin bad++; $display("FAIL mr_pre: got %b want 01", s_request); end
    tick();
    #4;
    total++; if (s_request !== 2'b00 || r_valid !== 1'b0) begin bad++; $display("FAIL mr_clear: got sreq=%b rv=%b want 00/0", s_request, r_valid); end
    total++; if (dut.credits[0] !== 3'd0) begin bad++; $display("FAIL mr_credit: got %0d want 0", dut.credits[0]); end
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_abort();
    test_simul_resp();
    test_credit_stall();
    test_unmapped();
    test_mid_reset();
    total++; if (ovf_cnt !== 0) begin bad++; $display("FAIL fifo_overflow: got %0d pushes into full FIFO want 0", ovf_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
